// File: rtl/seg7_capture_decoder_if.sv
// Bus bundle between a 7-segment line driver (master) and seg7_capture_decoder (slave).
// seq_err exists only when SEG7_SEQ_CHECK_EN is defined.
interface seg7_capture_decoder_if #(
  parameter int unsigned ERR_W = 8
);
  logic             sample_en;
  logic [6:0]       seg_in;
  logic             dp_in;
  logic             sel_in;
  logic [3:0]       bcd_out;
  logic             dp_out;
  logic             valid_out;
  logic             locked;
  logic             bad_pattern;
  logic [ERR_W-1:0] err_count;
`ifdef SEG7_SEQ_CHECK_EN
  logic             seq_err;
`endif

  modport master (
    output sample_en, seg_in, dp_in, sel_in,
    input  bcd_out, dp_out, valid_out, locked, bad_pattern, err_count
`ifdef SEG7_SEQ_CHECK_EN
    , input seq_err
`endif
  );

  modport slave (
    input  sample_en, seg_in, dp_in, sel_in,
    output bcd_out, dp_out, valid_out, locked, bad_pattern, err_count
`ifdef SEG7_SEQ_CHECK_EN
    , output seq_err
`endif
  );
endinterface

// File: rtl/seg7_capture_decoder.sv
// Decodes sampled common-cathode 7-segment patterns back to hex once stable for STABLE_N samples.
// Optional macro SEG7_SEQ_CHECK_EN adds seq_err (accepted values must count up mod 16).
module seg7_capture_decoder #(
  parameter int unsigned STABLE_N = 3,
  parameter int unsigned ERR_W    = 8
) (
  input logic                  clk,
  input logic                  rst,
  seg7_capture_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED, HOLD_BAD} state_t;

  localparam logic [3:0] STABLE_CNT = 4'(STABLE_N);

  state_t           state, state_n;
  logic [7:0]       word, word_n;
  logic [3:0]       cnt, cnt_n;
  logic             fire;
  logic [4:0]       dec;
  logic [7:0]       sample;
  logic [3:0]       bcd_q;
  logic             dp_q;
  logic             valid_q;
  logic             bad_q;
  logic [ERR_W-1:0] err_q;

  // Returns {legal, value}
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h3F:   decode = 5'h10;
      7'h06:   decode = 5'h11;
      7'h5B:   decode = 5'h12;
      7'h4F:   decode = 5'h13;
      7'h66:   decode = 5'h14;
      7'h6D:   decode = 5'h15;
      7'h7D:   decode = 5'h16;
      7'h07:   decode = 5'h17;
      7'h7F:   decode = 5'h18;
      7'h6F:   decode = 5'h19;
      7'h77:   decode = 5'h1A;
      7'h7C:   decode = 5'h1B;
      7'h39:   decode = 5'h1C;
      7'h5E:   decode = 5'h1D;
      7'h79:   decode = 5'h1E;
      7'h71:   decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  assign sample = {bus.dp_in, bus.seg_in};
  assign dec    = decode(bus.seg_in);

  // Acceptance is resolved in the same cycle as the completing sample so the
  // valid/bad pulse lands one clock after that sample.
  always_comb begin
    state_n = state;
    word_n  = word;
    cnt_n   = cnt;
    fire    = 1'b0;
    if (bus.sample_en) begin
      if (!bus.sel_in) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        case (state)
          IDLE: begin
            word_n  = sample;
            cnt_n   = 4'd1;
            state_n = SETTLE;
          end
          SETTLE: begin
            if (sample == word) begin
              cnt_n = cnt + 4'd1;
            end else begin
              word_n = sample;
              cnt_n  = 4'd1;
            end
          end
          default: begin
            if (sample != word) begin
              word_n  = sample;
              cnt_n   = 4'd1;
              state_n = SETTLE;
            end
          end
        endcase
        if (state_n == SETTLE && cnt_n == STABLE_CNT) begin
          fire    = 1'b1;
          state_n = dec[4] ? LOCKED : HOLD_BAD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      word    <= '0;
      cnt     <= '0;
      bcd_q   <= '0;
      dp_q    <= 1'b0;
      valid_q <= 1'b0;
      bad_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state   <= state_n;
      word    <= word_n;
      cnt     <= cnt_n;
      valid_q <= fire && dec[4];
      bad_q   <= fire && !dec[4];
      if (fire && dec[4]) begin
        bcd_q <= dec[3:0];
        dp_q  <= bus.dp_in;
      end
      if (fire && !dec[4] && err_q != '1) begin
        err_q <= err_q + 1'b1;
      end
    end
  end

`ifdef SEG7_SEQ_CHECK_EN
  logic       seq_q;
  logic       have_ref;
  logic [3:0] ref_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q    <= 1'b0;
      have_ref <= 1'b0;
      ref_val  <= '0;
    end else begin
      seq_q <= 1'b0;
      if (fire && dec[4]) begin
        seq_q    <= have_ref && (dec[3:0] != ref_val + 4'd1);
        have_ref <= 1'b1;
        ref_val  <= dec[3:0];
      end
    end
  end

  assign bus.seq_err = seq_q;
`endif

  assign bus.bcd_out     = bcd_q;
  assign bus.dp_out      = dp_q;
  assign bus.valid_out   = valid_q;
  assign bus.locked      = (state == LOCKED);
  assign bus.bad_pattern = bad_q;
  assign bus.err_count   = err_q;
endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed, table-driven bench for seg7_capture_decoder (STABLE_N=3, ERR_W=8).
module tb_seg7_capture_decoder;
  logic clk = 1'b0;
  logic rst;

  seg7_capture_decoder_if #(.ERR_W(8)) bus ();

  seg7_capture_decoder #(.STABLE_N(3), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       en;
    logic       sel;
    logic [7:0] w;
    logic       v;
    logic [3:0] b;
    logic       d;
    logic       l;
    logic       bad;
    logic [7:0] err;
    logic       seq;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  logic [3:0] e_bcd;
  logic       e_dp;
  logic [7:0] e_err;
  logic [6:0] gl[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic row(input logic r, input logic en, input logic sel, input logic [7:0] w,
                     input logic v, input logic [3:0] b, input logic d, input logic l,
                     input logic bad, input logic [7:0] err, input logic seq);
    vec_t t;
    t.r = r; t.en = en; t.sel = sel; t.w = w; t.v = v; t.b = b; t.d = d;
    t.l = l; t.bad = bad; t.err = err; t.seq = seq;
    tbl.push_back(t);
  endtask

  // Three samples of a new word (differing from the held one); last one accepts or flags.
  task automatic glyph3(input logic [7:0] w, input logic legal, input logic [3:0] val,
                        input logic seq);
    row(0, 1, 1, w, 0, e_bcd, e_dp, 0, 0, e_err, 0);
    row(0, 1, 1, w, 0, e_bcd, e_dp, 0, 0, e_err, 0);
    if (legal) begin
      e_bcd = val;
      e_dp  = w[7];
      row(0, 1, 1, w, 1, e_bcd, e_dp, 1, 0, e_err, seq);
    end else begin
      e_err = e_err + 8'd1;
      row(0, 1, 1, w, 0, e_bcd, e_dp, 0, 1, e_err, 0);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic sel, input logic [7:0] w);
    rst           = r;
    bus.sample_en = en;
    bus.sel_in    = sel;
    bus.dp_in     = w[7];
    bus.seg_in    = w[6:0];
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic v, input logic [3:0] b, input logic d,
                         input logic l, input logic bad, input logic [7:0] err,
                         input logic seq);
    chk("valid_out", idx, 32'(bus.valid_out), 32'(v));
    chk("bcd_out", idx, 32'(bus.bcd_out), 32'(b));
    chk("dp_out", idx, 32'(bus.dp_out), 32'(d));
    chk("locked", idx, 32'(bus.locked), 32'(l));
    chk("bad_pattern", idx, 32'(bus.bad_pattern), 32'(bad));
    chk("err_count", idx, 32'(bus.err_count), 32'(err));
`ifdef SEG7_SEQ_CHECK_EN
    chk("seq_err", idx, 32'(bus.seq_err), 32'(seq));
`else
    if (seq === 1'bx) $display("seq expectation undefined at step %0d", idx);
`endif
  endtask

  initial begin
    rst = 1'b1; bus.sample_en = 1'b0; bus.sel_in = 1'b0; bus.dp_in = 1'b0; bus.seg_in = '0;
    e_bcd = '0; e_dp = 1'b0; e_err = '0;

    row(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    row(1, 1, 1, 8'h3F, 0, 0, 0, 0, 0, 0, 0);
    glyph3(8'h3F, 1, 4'h0, 0);
    row(0, 1, 1, 8'h3F, 0, 4'h0, 0, 1, 0, 0, 0);
    row(0, 0, 1, 8'h06, 0, 4'h0, 0, 1, 0, 0, 0);
    row(0, 1, 1, 8'h06, 0, 4'h0, 0, 0, 0, 0, 0);
    row(0, 1, 1, 8'h06, 0, 4'h0, 0, 0, 0, 0, 0);
    glyph3(8'h5B, 1, 4'h2, 1);
    glyph3(8'hF1, 1, 4'hF, 1);
    glyph3(8'h00, 0, 4'h0, 0);
    row(0, 1, 1, 8'h00, 0, 4'hF, 1, 0, 0, 1, 0);
    glyph3(8'h07, 1, 4'h7, 1);
    row(0, 1, 0, 8'h07, 0, 4'h7, 0, 0, 0, 1, 0);
    row(0, 0, 0, 8'h07, 0, 4'h7, 0, 0, 0, 1, 0);
    glyph3(8'h07, 1, 4'h7, 1);
    row(0, 0, 0, 8'h07, 0, 4'h7, 0, 1, 0, 1, 0);
    row(0, 1, 1, 8'h4F, 0, 4'h7, 0, 0, 0, 1, 0);
    row(0, 1, 1, 8'h4F, 0, 4'h7, 0, 0, 0, 1, 0);
    row(1, 1, 1, 8'h4F, 0, 4'h0, 0, 0, 0, 0, 0);
    e_bcd = '0; e_dp = 1'b0; e_err = '0;
    glyph3(8'h4F, 1, 4'h3, 0);
    for (int k = 4; k < 20; k++) glyph3({1'b0, gl[k % 16]}, 1, 4'(k % 16), 0);
    glyph3(8'h6D, 1, 4'h5, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].en, tbl[i].sel, tbl[i].w);
      chk_all(i, tbl[i].v, tbl[i].b, tbl[i].d, tbl[i].l, tbl[i].bad, tbl[i].err, tbl[i].seq);
    end

    // sample_en low holds a partial stability count
    step(0, 1, 1, 8'h7D); chk_all(1000, 0, 4'h5, 0, 0, 0, 0, 0);
    step(0, 1, 1, 8'h7D); chk_all(1001, 0, 4'h5, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 8'h7D); chk_all(1002 + i, 0, 4'h5, 0, 0, 0, 0, 0);
    end
    step(0, 1, 1, 8'h7D); chk_all(1006, 1, 4'h6, 0, 1, 0, 0, 0);

    // sel_in low mid-settle restarts the count
    step(0, 1, 1, 8'h7F); step(0, 1, 1, 8'h7F);
    step(0, 1, 0, 8'h7F); chk_all(1010, 0, 4'h6, 0, 0, 0, 0, 0);
    step(0, 1, 1, 8'h7F); step(0, 1, 1, 8'h7F); chk_all(1011, 0, 4'h6, 0, 0, 0, 0, 0);
    step(0, 1, 1, 8'h7F); chk_all(1012, 1, 4'h8, 0, 1, 0, 0, 1);

    // error counter saturation over 258 bad patterns
    for (int i = 0; i < 258; i++) begin
      logic [7:0] w;
      w = (i % 2 == 0) ? 8'h00 : 8'h01;
      step(0, 1, 1, w);
      chk("bad_repeat", 2000 + i, 32'(bus.bad_pattern), 32'd0);
      step(0, 1, 1, w);
      step(0, 1, 1, w);
      if (e_err != 8'hFF) e_err = e_err + 8'd1;
      chk("bad_pattern", 2000 + i, 32'(bus.bad_pattern), 32'd1);
      chk("err_count", 2000 + i, 32'(bus.err_count), 32'(e_err));
    end
    chk("err_sat", 3000, 32'(bus.err_count), 32'hFF);
    chk("bcd_hold", 3000, 32'(bus.bcd_out), 32'h8);
    chk("locked_bad", 3000, 32'(bus.locked), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg7_capture_decoder.md
Name: seg7_capture_decoder

Overview:
- Receive-side companion to the common-cathode one-digit BCD-to-7-segment driver.
- Samples the driver's segment, decimal-point and digit-select lines on a sample strobe.
- Waits for each pattern to be stable, then decodes it back to a 4-bit hex/BCD value and reports it with a one-cycle valid pulse.
- Counts illegal patterns. Used as a self-checking monitor in driver benches and as an on-board loopback checker next to the 2 Hz counter chain.

Parameters:
- STABLE_N, 3: consecutive identical samples required before a pattern is accepted (legal range 1..15).
- ERR_W, 8: width of the illegal-pattern error counter.

Ports:
- clk  input  1  system clock (50 MHz on board).
- rst  input  1  synchronous reset, active-high.
- sample_en  input  1  sample strobe. Inputs are evaluated only in cycles where it is high.
- seg_in  input  7  segment lines, active-high. Bit 0=a, 1=b, 2=c, 3=d, 4=e, 5=f, 6=g.
- dp_in  input  1  decimal point, active-high.
- sel_in  input  1  digit select. High means the digit is enabled.
- bcd_out  output  4  last accepted decoded value.
- dp_out  output  1  decimal point of the last accepted pattern.
- valid_out  output  1  one-cycle pulse when a new value is accepted.
- locked  output  1  high while the current input pattern is accepted and unchanged.
- bad_pattern  output  1  one-cycle pulse when a stable pattern is not a legal glyph.
- err_count  output  ERR_W  saturating count of bad_pattern pulses.

Behaviour:
- Everything is synchronous to clk. rst has priority over all other activity. Reset mid-operation discards any partial stability count.
- Reset values: bcd_out=0, dp_out=0, valid_out=0, locked=0, bad_pattern=0, err_count=0. Internal last-sample register = 0, stability count = 0, state = IDLE.
- Legal glyph table, seg_in hex to value:
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7
  - 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F
  - Every other code is illegal, including 00 (blank).
- A sample is the 8-bit word {dp_in, seg_in}, taken in a cycle where sample_en=1.
- State IDLE:
  - Entered on reset or when any sample is taken with sel_in=0.
  - While in IDLE, locked=0 and the stability count is cleared.
  - A sample with sel_in=1 stores the word, sets count=1, and moves to SETTLE. If STABLE_N=1, it instead moves straight to ACCEPT handling (below).
- State SETTLE:
  - A sample equal to the stored word increments the count.
  - A sample that differs stores the new word and sets count=1.
  - When the count reaches STABLE_N, do ACCEPT handling:
    - Legal glyph: on the next clk edge, update bcd_out/dp_out, pulse valid_out for 1 cycle, set locked=1, and go to LOCKED.
    - Illegal glyph: on the next clk edge, pulse bad_pattern, increment err_count (saturates at all-ones, no wrap), and go to HOLD_BAD.
- State LOCKED:
  - Equal samples: no action, and no repeated valid_out.
  - A differing sample: locked=0 on the next edge, store the word, count=1, go to SETTLE.
- State HOLD_BAD:
  - Same as LOCKED, except locked stays 0 and bad_pattern is not repeated.
- Latency: valid_out / bad_pattern assert exactly 1 clk after the sample_en cycle that completes stability.
- Simultaneous events:
  - sel_in=0 with sample_en=1 forces IDLE regardless of state.
  - sample_en=0 holds all state, including counts, indefinitely.
- bcd_out and dp_out retain the last accepted value through IDLE, SETTLE and HOLD_BAD. They change only on acceptance.

Optional Feature:
- Macro SEG7_SEQ_CHECK_EN.
- When defined: adds output seq_err (1 bit, reset 0).
  - On each acceptance after the first since reset, the new value must equal (previous accepted + 1) mod 16. Otherwise seq_err pulses for 1 cycle, aligned with valid_out.
  - The first acceptance after reset never flags.
  - The F to 0 transition is legal.
  - Illegal glyphs do not update the reference value.
- When undefined: no seq_err port and no comparison logic. All other behaviour is identical.

Test Plan:
- Reset then 3 samples of 0x3F, sel_in=1 -> valid_out pulses once, 1 clk after the 3rd sample; bcd_out=0, locked=1. A 4th identical sample gives no second pulse.
- Patterns 0x06, 0x06, 0x5B, 0x5B, 0x5B -> count restarts at 0x5B; single valid_out with bcd_out=2. bcd_out stays 0 (reset value) until then.
- 3 samples of {dp=1, 0x71} -> bcd_out=F, dp_out=1. Then 3 samples of 0x00 -> bad_pattern pulses once, err_count=1, bcd_out stays F, locked=0.
- Locked on 7, then one sample with sel_in=0 -> locked=0, state IDLE. Then 3 samples of 0x07 -> valid_out re-pulses with bcd_out=7.
- rst asserted after 2 of 3 matching samples -> all outputs 0. The next 2 samples do not produce valid_out; a 3rd does.
- With SEG7_SEQ_CHECK_EN: accept 0..F then 0 -> no seq_err. Accept 3 then 5 -> seq_err pulses together with valid_out. Force 2^ERR_W+2 bad patterns -> err_count holds at all-ones.
